// File: rtl/vx_dram_pkg.sv
// ============================================================================
//  Module   : vx_dram_pkg
//  Purpose  : Shared widths, defaults and response type for vx_dram_responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vx_dram_pkg;

    localparam int c_LINE_SIZE      = 64;
    localparam int c_ADDR_WIDTH     = 26;
    localparam int c_TAG_WIDTH      = 28;
    localparam int c_MEM_LINES_LOG2 = 10;
    localparam int c_LATENCY        = 4;
    localparam int c_RSPQ_SIZE      = 4;

    localparam int c_DATA_WIDTH     = 8 * c_LINE_SIZE;
    localparam int c_MEM_LINES      = 1 << c_MEM_LINES_LOG2;

    // Counter must hold the value RSPQ_SIZE itself, hence the +1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int c_CNT_WIDTH      = cnt_width(c_RSPQ_SIZE);

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] data;
        logic [c_TAG_WIDTH-1:0]  tag;
    } dram_rsp_t;

endpackage

`default_nettype wire

// File: rtl/vx_dram_rsp_fifo.sv
// ============================================================================
//  Module   : vx_dram_rsp_fifo
//  Purpose  : Synchronous response FIFO, power-of-2 depth, async active-high rst.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_dram_rsp_fifo
    import vx_dram_pkg::*;
#(
    parameter int  DEPTH   = c_RSPQ_SIZE,
    parameter type ENTRY_T = dram_rsp_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  ENTRY_T i_push_data,
    input  logic   i_pop,
    output ENTRY_T o_head,
    output logic   o_empty,
    output logic   o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    ENTRY_T           r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

`default_nettype wire

// File: rtl/vx_dram_responder.sv
// ============================================================================
//  Module   : vx_dram_responder
//  Purpose  : On-chip DRAM stand-in: line store, fixed read latency, in-order
//             tagged responses, credit-bounded queue. Option: VX_DRAM_OOB_CHECK_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_dram_responder
    import vx_dram_pkg::*;
#(
    parameter int LINE_SIZE      = c_LINE_SIZE,
    parameter int ADDR_WIDTH     = c_ADDR_WIDTH,
    parameter int TAG_WIDTH      = c_TAG_WIDTH,
    parameter int MEM_LINES_LOG2 = c_MEM_LINES_LOG2,
    parameter int LATENCY        = c_LATENCY,
    parameter int RSPQ_SIZE      = c_RSPQ_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   dram_req_valid,
    input  logic                   dram_req_rw,
    input  logic [LINE_SIZE-1:0]   dram_req_byteen,
    input  logic [ADDR_WIDTH-1:0]  dram_req_addr,
    input  logic [8*LINE_SIZE-1:0] dram_req_data,
    input  logic [TAG_WIDTH-1:0]   dram_req_tag,
    output logic                   dram_req_ready,

    output logic                   dram_rsp_valid,
    output logic [8*LINE_SIZE-1:0] dram_rsp_data,
    output logic [TAG_WIDTH-1:0]   dram_rsp_tag,
    input  logic                   dram_rsp_ready
`ifdef VX_DRAM_OOB_CHECK_EN
    ,
    output logic                   oob_err
`endif
);

    localparam int c_DATA_W    = 8 * LINE_SIZE;
    localparam int c_MEM_LINES = 1 << MEM_LINES_LOG2;
    localparam int c_CNT_W     = cnt_width(RSPQ_SIZE);

    typedef struct packed {
        logic [c_DATA_W-1:0]  data;
        logic [TAG_WIDTH-1:0] tag;
    } rsp_t;

    logic [c_CNT_W-1:0]        r_outstanding;
    logic [c_DATA_W-1:0]       r_mem   [c_MEM_LINES];
    logic [c_DATA_W-1:0]       r_pdata [LATENCY];
    logic [TAG_WIDTH-1:0]      r_ptag  [LATENCY];
    logic                      r_poob  [LATENCY];
    logic [LATENCY-1:0]        r_pv;

    logic                      w_req_ready;
    logic                      w_accept;
    logic                      w_rd_accept;
    logic                      w_wr_accept;
    logic                      w_rsp_fire;
    logic                      w_oob;
    logic [MEM_LINES_LOG2-1:0] w_idx;
    logic [ADDR_WIDTH-1:0]     w_addr_hi;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_push;
    rsp_t                      w_push_data;
    rsp_t                      w_head;

    // A read credit is taken at accept, so pipeline + FIFO can never exceed RSPQ_SIZE.
    assign w_req_ready = !reset && (r_outstanding < c_CNT_W'(RSPQ_SIZE));
    assign w_accept    = dram_req_valid && w_req_ready;
    assign w_rd_accept = w_accept && !dram_req_rw;
    assign w_wr_accept = w_accept && dram_req_rw;
    assign w_rsp_fire  = !w_fifo_empty && dram_rsp_ready;

    assign w_idx       = dram_req_addr[MEM_LINES_LOG2-1:0];
    assign w_addr_hi   = dram_req_addr >> MEM_LINES_LOG2;

`ifdef VX_DRAM_OOB_CHECK_EN
    logic r_oob_err;

    assign w_oob = |w_addr_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oob_err <= 1'b0;
        end else if (w_accept && w_oob) begin
            r_oob_err <= 1'b1;
        end
    end

    assign oob_err = r_oob_err;
`else
    logic w_unused_addr_hi;

    // Upper address bits alias onto the stored lines.
    assign w_oob            = 1'b0;
    assign w_unused_addr_hi = |w_addr_hi;
`endif

    // Line store plus the data/tag half of the read pipeline; none of it is reset.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !w_oob) begin
            for (int b = 0; b < LINE_SIZE; b++) begin
                if (dram_req_byteen[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= dram_req_data[b*8 +: 8];
                end
            end
        end
        r_pdata[0] <= r_mem[w_idx];
        r_ptag[0]  <= dram_req_tag;
        r_poob[0]  <= w_oob;
        for (int i = 1; i < LATENCY; i++) begin
            r_pdata[i] <= r_pdata[i-1];
            r_ptag[i]  <= r_ptag[i-1];
            r_poob[i]  <= r_poob[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_rd_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_accept, w_rsp_fire})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign w_push           = r_pv[LATENCY-1] && !w_fifo_full;
    assign w_push_data.data = r_poob[LATENCY-1] ? '0 : r_pdata[LATENCY-1];
    assign w_push_data.tag  = r_ptag[LATENCY-1];

    vx_dram_rsp_fifo #(
        .DEPTH   (RSPQ_SIZE),
        .ENTRY_T (rsp_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (dram_rsp_ready),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign dram_req_ready = w_req_ready;
    assign dram_rsp_valid = !w_fifo_empty;
    // Outputs read as zero whenever nothing is queued, including during reset.
    assign dram_rsp_data  = w_fifo_empty ? '0 : w_head.data;
    assign dram_rsp_tag   = w_fifo_empty ? '0 : w_head.tag;

endmodule

`default_nettype wire

// File: tb/tb_vx_dram_responder.sv
// ============================================================================
//  Module   : tb_vx_dram_responder
//  Purpose  : Directed + random bench for vx_dram_responder with a line/queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_dram_responder;

    localparam int LS  = 64;
    localparam int AW  = 26;
    localparam int TW  = 28;
    localparam int ML2 = 10;
    localparam int LAT = 4;
    localparam int RQ  = 4;
    localparam int DW  = 8 * LS;

    logic          clk;
    logic          reset;
    logic          dram_req_valid;
    logic          dram_req_rw;
    logic [LS-1:0] dram_req_byteen;
    logic [AW-1:0] dram_req_addr;
    logic [DW-1:0] dram_req_data;
    logic [TW-1:0] dram_req_tag;
    logic          dram_req_ready;
    logic          dram_rsp_valid;
    logic [DW-1:0] dram_rsp_data;
    logic [TW-1:0] dram_rsp_tag;
    logic          dram_rsp_ready;
`ifdef VX_DRAM_OOB_CHECK_EN
    logic          oob_err;
`endif

    vx_dram_responder #(
        .LINE_SIZE      (LS),
        .ADDR_WIDTH     (AW),
        .TAG_WIDTH      (TW),
        .MEM_LINES_LOG2 (ML2),
        .LATENCY        (LAT),
        .RSPQ_SIZE      (RQ)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dram_req_valid  (dram_req_valid),
        .dram_req_rw     (dram_req_rw),
        .dram_req_byteen (dram_req_byteen),
        .dram_req_addr   (dram_req_addr),
        .dram_req_data   (dram_req_data),
        .dram_req_tag    (dram_req_tag),
        .dram_req_ready  (dram_req_ready),
        .dram_rsp_valid  (dram_rsp_valid),
        .dram_rsp_data   (dram_rsp_data),
        .dram_rsp_tag    (dram_rsp_tag),
        .dram_rsp_ready  (dram_rsp_ready)
`ifdef VX_DRAM_OOB_CHECK_EN
        ,
        .oob_err         (oob_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: line array, expected-response queues, credit count.
    logic [DW-1:0] mmem [1 << ML2];
    logic [DW-1:0] q_data [$];
    logic [TW-1:0] q_tag  [$];
    int            q_cyc  [$];
    logic [TW-1:0] got_tags [$];
    int            out_cnt;
    int            n_chk;
    int            n_err;
    int            cyc;
    int            n_valid_seen;
    bit            accepted;
    bit            seen_valid;
    logic [DW-1:0] last_data;
    logic [TW-1:0] last_tag;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef VX_DRAM_OOB_CHECK_EN
        return (a >> ML2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input logic rw, input logic [AW-1:0] a,
                         input logic [LS-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t);
        dram_req_valid  = v;
        dram_req_rw     = rw;
        dram_req_addr   = a;
        dram_req_byteen = be;
        dram_req_data   = d;
        dram_req_tag    = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // One clock: sample at negedge, update the model, return just after posedge.
    task automatic tick();
        int ln;
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        chk("req_ready", DW'(dram_req_ready), DW'(!reset && (out_cnt < RQ)));
        if (dram_rsp_valid) begin
            seen_valid = 1'b1;
            n_valid_seen++;
            if (q_data.size() == 0) begin
                chk("rsp_unexpected", DW'(dram_rsp_valid), DW'(0));
            end else begin
                chk("rsp_data", dram_rsp_data, q_data[0]);
                chk("rsp_tag", DW'(dram_rsp_tag), DW'(q_tag[0]));
                if (dram_rsp_ready) begin
                    chk("rsp_min_latency", DW'((cyc - q_cyc[0]) >= LAT + 1), DW'(1));
                    last_data = dram_rsp_data;
                    last_tag  = dram_rsp_tag;
                    got_tags.push_back(dram_rsp_tag);
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                    void'(q_cyc.pop_front());
                    out_cnt--;
                end
            end
        end
        if (dram_req_valid && dram_req_ready) begin
            accepted = 1'b1;
            ln = int'(dram_req_addr % (1 << ML2));
            if (dram_req_rw) begin
                if (!is_oob(dram_req_addr))
                    for (int b = 0; b < LS; b++)
                        if (dram_req_byteen[b]) mmem[ln][b*8 +: 8] = dram_req_data[b*8 +: 8];
            end else begin
                q_data.push_back(is_oob(dram_req_addr) ? '0 : mmem[ln]);
                q_tag.push_back(dram_req_tag);
                q_cyc.push_back(cyc);
                out_cnt++;
            end
        end
        chk("outstanding_max", DW'(out_cnt <= RQ), DW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [LS-1:0] be,
                         input logic [DW-1:0] d, input logic [TW-1:0] t);
        int g;
        drive(1'b1, rw, a, be, d, t);
        g = 0;
        do begin
            tick();
            g++;
        end while (!accepted && g < 20);
        chk("req_accept", DW'(accepted), DW'(1));
        idle();
    endtask

    task automatic drain();
        int g;
        idle();
        dram_rsp_ready = 1'b1;
        g = 0;
        while (q_data.size() > 0 && g < 60) begin
            tick();
            g++;
        end
        chk("drain_empty", DW'(q_data.size()), DW'(0));
    endtask

    initial begin
        int            acc_cyc;
        int            g;
        int            t;
        int            n_acc;
        logic [DW-1:0] d;
        logic [AW-1:0] a;

        n_chk = 0; n_err = 0; cyc = 0; out_cnt = 0; n_valid_seen = 0;
        seen_valid = 0; accepted = 0; last_data = '0; last_tag = '0;
        reset = 1'b1;
        dram_rsp_ready = 1'b1;
        idle();

        #3;
        chk("reset_req_ready", DW'(dram_req_ready), DW'(0));
        chk("reset_rsp_valid", DW'(dram_rsp_valid), DW'(0));
        chk("reset_rsp_data", dram_rsp_data, '0);
        chk("reset_rsp_tag", DW'(dram_rsp_tag), DW'(0));
`ifdef VX_DRAM_OOB_CHECK_EN
        chk("reset_oob_err", DW'(oob_err), DW'(0));
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 32; i++) issue(1'b1, AW'(i), '1, rand_line(), '0);

        // Write then read next cycle; response five cycles after the read is accepted.
        issue(1'b1, AW'('h10), '1, {LS{8'hA5}}, '0);
        issue(1'b0, AW'('h10), '0, '0, TW'('h3));
        acc_cyc = cyc;
        seen_valid = 1'b0;
        g = 0;
        while (!seen_valid && g < 20) begin
            tick();
            g++;
        end
        chk("rd_latency", DW'(cyc - acc_cyc), DW'(LAT + 1));
        drain();
        chk("raw_data", last_data, {LS{8'hA5}});
        chk("raw_tag", DW'(last_tag), DW'(3));

        // Byte-masked write only touches byte 0.
        issue(1'b1, AW'(5), '1, '0, '0);
        d = rand_line();
        d[7:0] = 8'hFF;
        issue(1'b1, AW'(5), LS'(1), d, '0);
        issue(1'b0, AW'(5), '0, '0, TW'('h55));
        drain();
        chk("partial_line", last_data, DW'(8'hFF));

        // Credit limit with the response side stalled.
        dram_rsp_ready = 1'b0;
        got_tags.delete();
        t = 1;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (t <= 6) drive(1'b1, 1'b0, AW'(t), '0, '0, TW'(t));
            else idle();
            tick();
            if (accepted) begin
                t++;
                n_acc++;
            end
        end
        chk("bp_accepted", DW'(n_acc), DW'(RQ));
        chk("bp_req_ready_low", DW'(dram_req_ready), DW'(0));
        dram_rsp_ready = 1'b1;
        g = 0;
        while ((t <= 6 || q_data.size() > 0) && g < 60) begin
            if (t <= 6) drive(1'b1, 1'b0, AW'(t), '0, '0, TW'(t));
            else idle();
            tick();
            if (accepted) t++;
            g++;
        end
        idle();
        chk("bp_count", DW'(got_tags.size()), DW'(6));
        for (int i = 0; i < got_tags.size() && i < 6; i++)
            chk("bp_tag_order", DW'(got_tags[i]), DW'(i + 1));

        // Alias / out-of-range handling.
`ifdef VX_DRAM_OOB_CHECK_EN
        issue(1'b0, AW'('h400), '0, '0, TW'('h7));
        chk("oob_err_set", DW'(oob_err), DW'(1));
        drain();
        chk("oob_rd_data", last_data, '0);
        chk("oob_rd_tag", DW'(last_tag), DW'(7));
        d = mmem[0];
        issue(1'b1, AW'('h400), '1, '1, '0);
        issue(1'b0, AW'(0), '0, '0, TW'('h8));
        drain();
        chk("oob_wr_dropped", last_data, d);
        chk("oob_err_sticky", DW'(oob_err), DW'(1));
`else
        d = rand_line();
        issue(1'b1, AW'('h405), '1, d, '0);
        issue(1'b0, AW'(5), '0, '0, TW'('h9));
        drain();
        chk("alias_data", last_data, d);
`endif

        // Random mixed traffic with random response back-pressure.
        for (int i = 0; i < 400; i++) begin
            a = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | (AW'($urandom_range(1, 15)) << ML2);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
                  {$urandom(), $urandom()}, rand_line(), TW'($urandom()));
            dram_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with three reads in flight discards them.
        for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, '0, TW'(i + 20));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", DW'(dram_rsp_valid), DW'(0));
        chk("midrst_req_ready", DW'(dram_req_ready), DW'(0));
        chk("midrst_rsp_tag", DW'(dram_rsp_tag), DW'(0));
        q_data.delete();
        q_tag.delete();
        q_cyc.delete();
        out_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_valid_seen = 0;
        repeat (12) tick();
        chk("no_rsp_after_reset", DW'(n_valid_seen), DW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
